encrypt_stream_unit: RTL

Parametrised streaming encrypt/decrypt engine, the next generation of the fixed-key byte encryptor. Each beat is bit-permuted (rotate) and XORed with a key drawn from a loadable key ring that advances at a programmable beat rate. Encrypt or decrypt mode is selected at start. The block sits between an upstream data source and a downstream sink, using valid/ready handshakes on both sides with full backpressure.

---
 rtl/encrypt_stream_pkg.sv | 43 ++++
 rtl/encrypt_stream_unit_key_ring.sv | 70 +++++++
 rtl/encrypt_stream_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/encrypt_stream_pkg.sv
// Shared types and bit-permutation helpers for the streaming encrypt/decrypt engine.
package encrypt_stream_pkg;

    localparam int unsigned MAX_DW = 64;
    localparam int unsigned MAX_IW = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [MAX_DW-1:0] KEY_RST = '0;

    // Rotate the low w bits of x left by amt; bits at and above w are zero.
    function automatic logic [MAX_DW-1:0] rol(input logic [MAX_DW-1:0] x,
                                              input int unsigned       amt,
                                              input int unsigned       w);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (i < w) begin
                r[MAX_IW'(i)] = x[MAX_IW'((i + w - amt) % w)];
            end
        end
        return r;
    endfunction

    // Rotate the low w bits of x right by amt; bits at and above w are zero.
    function automatic logic [MAX_DW-1:0] ror(input logic [MAX_DW-1:0] x,
                                              input int unsigned       amt,
                                              input int unsigned       w);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (i < w) begin
                r[MAX_IW'(i)] = x[MAX_IW'((i + amt) % w)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/encrypt_stream_unit_key_ring.sv
// Loadable key ring with a beat counter that advances the read pointer every rate beats.
module encrypt_key_ring
    import encrypt_stream_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned NKEYS = 3,
    parameter int unsigned ROT_W = 3,
    parameter int unsigned KIW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [KIW-1:0]   widx_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic             restart_i,
    input  logic [ROT_W-1:0] rate_i,
    input  logic             accept_i,
    output logic [DW-1:0]    key_o
);

    logic [DW-1:0]    keys_q [NKEYS];
    logic [KIW-1:0]   ptr_q, ptr_d;
    logic [ROT_W-1:0] cnt_q, cnt_d;
    logic [ROT_W-1:0] rate_q, rate_d;

    // Pointer/counter update; a rate of zero pins the pointer to entry 0.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        rate_d = rate_q;
        if (restart_i) begin
            ptr_d  = '0;
            cnt_d  = '0;
            rate_d = rate_i;
        end else if (accept_i && (rate_q != '0)) begin
            if (cnt_q == rate_q - ROT_W'(1)) begin
                cnt_d = '0;
                ptr_d = (32'(ptr_q) == NKEYS - 1) ? '0 : ptr_q + KIW'(1);
            end else begin
                cnt_d = cnt_q + ROT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            rate_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            rate_q <= rate_d;
        end
    end

    // Out-of-range indices are dropped rather than aliased onto a real entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NKEYS; i++) begin
                keys_q[i] <= DW'(KEY_RST);
            end
        end else if (we_i && (32'(widx_i) < NKEYS)) begin
            keys_q[widx_i] <= wdata_i;
        end
    end

    assign key_o = keys_q[ptr_q];

endmodule

// File: rtl/encrypt_stream_unit.sv
// Streaming rotate+XOR encrypt/decrypt engine: control FSM, valid/ready handshakes
// and a two-stage datapath (stage-1 register, then output register).
module encrypt_stream_unit
    import encrypt_stream_pkg::*;
#(
    parameter  int unsigned DW       = 8,
    parameter  int unsigned NKEYS    = 3,
    parameter  int unsigned ROT_W    = 3,
    parameter  int unsigned PERM_ROT = 3,
    localparam int unsigned KIW      = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic             mode,
    input  logic [ROT_W-1:0] rot_freq,
    input  logic             key_we,
    input  logic [KIW-1:0]   key_idx,
    input  logic [DW-1:0]    key_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    dout,
    output logic             busy
);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic [DW-1:0] s1_key_q, s1_key_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] dout_q, dout_d;

    logic          adv_c;
    logic          accept_c;
    logic          start_c;
    logic          key_we_c;
    logic [DW-1:0] key_c;
    logic [DW-1:0] xform_c;

    assign adv_c    = !out_valid_q || out_ready;
    assign in_ready = (state_q == RUN) && (!s1_valid_q || adv_c);
    assign accept_c = in_valid && in_ready;
    assign start_c  = (state_q == IDLE) && cfg_start;
    assign key_we_c = (state_q == IDLE) && key_we;

    encrypt_key_ring #(
        .DW    (DW),
        .NKEYS (NKEYS),
        .ROT_W (ROT_W),
        .KIW   (KIW)
    ) u_key_ring (
        .clk       (clk),
        .rst_n     (rst),
        .we_i      (key_we_c),
        .widx_i    (key_idx),
        .wdata_i   (key_data),
        .restart_i (start_c),
        .rate_i    (rot_freq),
        .accept_i  (accept_c),
        .key_o     (key_c)
    );

    // Decrypt undoes encrypt: XOR first, then rotate back the other way.
    always_comb begin
        if (mode_q) begin
            xform_c = DW'(ror(MAX_DW'(s1_data_q ^ s1_key_q), PERM_ROT, DW));
        end else begin
            xform_c = DW'(rol(MAX_DW'(s1_data_q), PERM_ROT, DW)) ^ s1_key_q;
        end
    end

    // Next-state: control FSM plus pipeline movement.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_key_d    = s1_key_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = RUN;
                    mode_d  = mode;
                end
            end
            RUN: begin
                if (cfg_stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid_q && adv_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv_c) begin
            out_valid_d = s1_valid_q;
            s1_valid_d  = 1'b0;
            if (s1_valid_q) begin
                dout_d = xform_c;
            end
        end
        if (accept_c) begin
            s1_valid_d = 1'b1;
            s1_data_d  = din;
            s1_key_d   = key_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_key_q    <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_key_q    <= s1_key_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign busy      = (state_q != IDLE);

endmodule
